csi2_packet_parser: RTL and testbench

Parses the 32-bit merged-lane byte stream from the CSI-2 D-PHY receiver into packets, ahead of the RAW10 unpacker.
- Decodes short packets (FS/FE/LS/LE) into sync pulses and levels.
- Filters long packets by virtual channel and data type.
- Strips the header and CRC footer, and forwards payload words with byte strobes.
- Feeds the RAW10 unpacker's `data_i` / `data_valid_i` and the `fsync_o` / `lsync_o` host outputs.

---
 rtl/csi2_packet_parser_if.sv | 19 +
 rtl/csi2_packet_parser.sv | 182 ++++++++++++++++++
 tb/tb_csi2_packet_parser.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi2_packet_parser_if.sv
// Lane-merged input stream and forwarded payload bus of the CSI-2 packet parser.
interface csi2_packet_parser_if;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic [31:0] payload_o;
  logic [3:0]  payload_strb_o;
  logic        payload_valid_o;
  logic        payload_last_o;

  modport master (
    output data_i, data_valid_i,
    input  payload_o, payload_strb_o, payload_valid_o, payload_last_o
  );

  modport slave (
    input  data_i, data_valid_i,
    output payload_o, payload_strb_o, payload_valid_o, payload_last_o
  );
endinterface

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: short-packet sync decode, VC/DT filtering, payload forwarding.
// Optional header ECC check enabled by defining CSI2_ECC_CHECK_EN.
module csi2_packet_parser #(
  parameter logic [1:0] VC_SEL = 2'd0,
  parameter logic [5:0] DT_SEL = 6'h2B
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  csi2_packet_parser_if.slave         bus,
  output logic                        frame_start_o,
  output logic                        frame_end_o,
  output logic                        line_start_o,
  output logic                        line_end_o,
  output logic                        fsync_o,
  output logic                        lsync_o,
  output logic [15:0]                 line_count_o,
  output logic                        ecc_err_o,
  output logic                        trunc_err_o,
  output logic                        pkt_drop_o
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

  state_t      state_q;
  logic [15:0] rem_q;
  logic [15:0] line_cnt_q;
  logic        fs_q, fe_q, ls_q, le_q, fsync_q, lsync_q;
  logic        ecc_err_q, trunc_q, drop_q;
  logic [31:0] pay_q;
  logic [3:0]  strb_q;
  logic        pvalid_q, plast_q;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_ok;
  logic [3:0]  strb_d;
  logic        last_d;
  logic [15:0] rem_d;

  assign hdr_vc = bus.data_i[7:6];
  assign hdr_dt = bus.data_i[5:0];
  assign hdr_wc = {bus.data_i[23:16], bus.data_i[15:8]};

`ifdef CSI2_ECC_CHECK_EN
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    ecc6[0] = ^(d & 24'hF12CB7);
    ecc6[1] = ^(d & 24'hF2555B);
    ecc6[2] = ^(d & 24'h749A6D);
    ecc6[3] = ^(d & 24'hB8E38E);
    ecc6[4] = ^(d & 24'hDF03F0);
    ecc6[5] = ^(d & 24'hEFFC00);
  endfunction

  assign hdr_ok = (bus.data_i[31:24] == {2'b00, ecc6(bus.data_i[23:0])});
`else
  logic unused_ecc_byte;
  assign unused_ecc_byte = ^bus.data_i[31:24];
  assign hdr_ok = 1'b1;
`endif

  always_comb begin
    last_d = (rem_q <= 16'd4);
    rem_d  = last_d ? '0 : rem_q - 16'd4;
    strb_d = 4'hF;
    if (last_d) begin
      case (rem_q[2:0])
        3'd4:    strb_d = 4'hF;
        3'd3:    strb_d = 4'h7;
        3'd2:    strb_d = 4'h3;
        3'd1:    strb_d = 4'h1;
        default: strb_d = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      line_cnt_q <= '0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      ls_q       <= 1'b0;
      le_q       <= 1'b0;
      fsync_q    <= 1'b0;
      lsync_q    <= 1'b0;
      ecc_err_q  <= 1'b0;
      trunc_q    <= 1'b0;
      drop_q     <= 1'b0;
      pay_q      <= '0;
      strb_q     <= '0;
      pvalid_q   <= 1'b0;
      plast_q    <= 1'b0;
    end else begin
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      ls_q      <= 1'b0;
      le_q      <= 1'b0;
      ecc_err_q <= 1'b0;
      trunc_q   <= 1'b0;
      drop_q    <= 1'b0;
      pay_q     <= '0;
      strb_q    <= '0;
      pvalid_q  <= 1'b0;
      plast_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.data_valid_i) begin
            state_q <= DRAIN;
            if (!hdr_ok) begin
              ecc_err_q <= 1'b1;
            end else if (hdr_vc != VC_SEL) begin
              state_q <= DRAIN;
            end else if (hdr_dt == DT_SEL) begin
              line_cnt_q <= line_cnt_q + 16'd1;
              if (hdr_wc != '0) begin
                rem_q   <= hdr_wc;
                lsync_q <= 1'b1;
                state_q <= PAYLOAD;
              end
            end else begin
              case (hdr_dt)
                6'h00: begin
                  fs_q       <= 1'b1;
                  fsync_q    <= 1'b1;
                  line_cnt_q <= '0;
                end
                6'h01: begin
                  fe_q    <= 1'b1;
                  fsync_q <= 1'b0;
                end
                6'h02:   ls_q <= 1'b1;
                6'h03:   le_q <= 1'b1;
                default: drop_q <= (hdr_dt >= 6'h10);
              endcase
            end
          end
        end
        PAYLOAD: begin
          if (bus.data_valid_i) begin
            pvalid_q <= 1'b1;
            pay_q    <= bus.data_i;
            strb_q   <= strb_d;
            plast_q  <= last_d;
            rem_q    <= rem_d;
            if (last_d) begin
              lsync_q <= 1'b0;
              state_q <= DRAIN;
            end
          end else begin
            // burst ended with payload still owed: abort without a last beat
            trunc_q <= 1'b1;
            lsync_q <= 1'b0;
            rem_q   <= '0;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (!bus.data_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.payload_o       = pay_q;
  assign bus.payload_strb_o  = strb_q;
  assign bus.payload_valid_o = pvalid_q;
  assign bus.payload_last_o  = plast_q;
  assign frame_start_o       = fs_q;
  assign frame_end_o         = fe_q;
  assign line_start_o        = ls_q;
  assign line_end_o          = le_q;
  assign fsync_o             = fsync_q;
  assign lsync_o             = lsync_q;
  assign line_count_o        = line_cnt_q;
  assign ecc_err_o           = ecc_err_q;
  assign trunc_err_o         = trunc_q;
  assign pkt_drop_o          = drop_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser with a payload scoreboard; honours CSI2_ECC_CHECK_EN.
module tb_csi2_packet_parser;

  logic        clk;
  logic        rst_n;
  logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic        fsync_o, lsync_o, ecc_err_o, trunc_err_o, pkt_drop_o;
  logic [15:0] line_count_o;

  csi2_packet_parser_if bus ();

  csi2_packet_parser #(.VC_SEL(2'd0), .DT_SEL(6'h2B)) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .bus           (bus),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .line_start_o  (line_start_o),
    .line_end_o    (line_end_o),
    .fsync_o       (fsync_o),
    .lsync_o       (lsync_o),
    .line_count_o  (line_count_o),
    .ecc_err_o     (ecc_err_o),
    .trunc_err_o   (trunc_err_o),
    .pkt_drop_o    (pkt_drop_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_fs = 0, n_fe = 0, n_ls = 0, n_le = 0, n_drop = 0, n_trunc = 0, n_ecc = 0;
  int n_last = 0, n_lsync = 0;
  int snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ecc_col(input int unsigned i);
    case (i)
      0: ecc_col = 6'h07;  1: ecc_col = 6'h0B;  2: ecc_col = 6'h0D;  3: ecc_col = 6'h0E;
      4: ecc_col = 6'h13;  5: ecc_col = 6'h15;  6: ecc_col = 6'h16;  7: ecc_col = 6'h19;
      8: ecc_col = 6'h1A;  9: ecc_col = 6'h1C; 10: ecc_col = 6'h23; 11: ecc_col = 6'h25;
     12: ecc_col = 6'h26; 13: ecc_col = 6'h29; 14: ecc_col = 6'h2A; 15: ecc_col = 6'h2C;
     16: ecc_col = 6'h31; 17: ecc_col = 6'h32; 18: ecc_col = 6'h34; 19: ecc_col = 6'h38;
     20: ecc_col = 6'h1F; 21: ecc_col = 6'h2F; 22: ecc_col = 6'h37; 23: ecc_col = 6'h3B;
      default: ecc_col = 6'h00;
    endcase
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  p;
    d = {wc[15:8], wc[7:0], di};
    p = '0;
    for (int unsigned i = 0; i < 24; i++) if (d[i]) p = p ^ ecc_col(i);
    return {2'b00, p, d};
  endfunction

  // Monitor: pulse/level tallies and scoreboard comparison of forwarded payload.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start_o) n_fs++;
      if (frame_end_o)   n_fe++;
      if (line_start_o)  n_ls++;
      if (line_end_o)    n_le++;
      if (pkt_drop_o)    n_drop++;
      if (trunc_err_o)   n_trunc++;
      if (ecc_err_o)     n_ecc++;
      if (lsync_o)       n_lsync++;
      if (bus.payload_valid_o) begin
        if (bus.payload_last_o) n_last++;
        if (sb_q.size() == 0) begin
          check("payload_extra", 64'(bus.payload_valid_o), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("payload_data", 64'(bus.payload_o), 64'(e.data));
          check("payload_strb", 64'(bus.payload_strb_o), 64'(e.strb));
          check("payload_last", 64'(bus.payload_last_o), 64'(e.last));
        end
      end else begin
        check("payload_idle_zero",
              64'({bus.payload_o, bus.payload_strb_o, bus.payload_last_o}), 64'(0));
      end
    end
  end

  // Drives one burst (header + nwords) starting at a negedge; predicts forwarded words.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc,
                          input int unsigned nwords, input logic [7:0] ecc_xor);
    logic [31:0] h, w;
    logic        accept;
    int unsigned rem, n;
    exp_t        e;
    h = mk_hdr(di, wc);
    h[31:24] = h[31:24] ^ ecc_xor;
    accept = (di[7:6] == 2'd0) && (di[5:0] == 6'h2B) && (wc != 16'd0);
`ifdef CSI2_ECC_CHECK_EN
    if (ecc_xor != 8'h00) accept = 1'b0;
`endif
    bus.data_i = h;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    rem = 32'(wc);
    for (int unsigned i = 0; i < nwords; i++) begin
      w = $urandom;
      bus.data_i = w;
      if (accept && rem > 0) begin
        n = (rem > 4) ? 4 : rem;
        e.data = w;
        e.strb = 4'((1 << n) - 1);
        e.last = (rem <= 4);
        sb_q.push_back(e);
        rem = rem - n;
      end
      @(negedge clk);
    end
    bus.data_valid_i = 1'b0;
    bus.data_i = $urandom;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    exp_t        e;
    rst_n = 1'b0;
    bus.data_i = '0;
    bus.data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_fsync", 64'(fsync_o), 64'(0));
    check("reset_pvalid", 64'(bus.payload_valid_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_lsync", 64'(lsync_o), 64'(0));
    check("reset_line_count", 64'(line_count_o), 64'(0));
    check("reset_payload", 64'(bus.payload_o), 64'(0));

    // FS as one-word burst: pulse exactly at N+1
    bus.data_i = 32'h00000000;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    check("fs_pulse", 64'(frame_start_o), 64'(1));
    check("fs_fsync", 64'(fsync_o), 64'(1));
    check("fs_line_count", 64'(line_count_o), 64'(0));
    @(negedge clk);
    check("fs_pulse_single", 64'(frame_start_o), 64'(0));
    @(negedge clk);

    bus.data_i = 32'h07000001;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    check("fe_pulse", 64'(frame_end_o), 64'(1));
    check("fe_fsync", 64'(fsync_o), 64'(0));
    repeat (2) @(negedge clk);

    send_pkt(8'h01, 16'd0, 0, 8'h00);
    check("fe_low_count", 64'(n_fe), 64'(2));
    check("fe_low_fsync", 64'(fsync_o), 64'(0));

    send_pkt(8'h00, 16'd0, 0, 8'h00);
    check("fs2_count", 64'(n_fs), 64'(2));
    check("fs2_fsync", 64'(fsync_o), 64'(1));

    snap = n_lsync;
    send_pkt(8'h2B, 16'd10, 3, 8'h00);
    check("wc10_line_count", 64'(line_count_o), 64'(1));
    check("wc10_lsync_cycles", 64'(n_lsync - snap), 64'(3));
    check("wc10_last_count", 64'(n_last), 64'(1));
    check("wc10_sb_drained", 64'(sb_q.size()), 64'(0));

    send_pkt(8'h2B, 16'd8, 3, 8'h00);
    check("wc8_line_count", 64'(line_count_o), 64'(2));
    check("wc8_last_count", 64'(n_last), 64'(2));
    check("wc8_sb_drained", 64'(sb_q.size()), 64'(0));

    send_pkt(8'h6B, 16'd4, 2, 8'h00);
    check("vc1_drop", 64'(n_drop), 64'(0));
    check("vc1_line_count", 64'(line_count_o), 64'(2));
    send_pkt(8'h2A, 16'd4, 2, 8'h00);
    check("raw8_drop", 64'(n_drop), 64'(1));
    check("raw8_line_count", 64'(line_count_o), 64'(2));
    send_pkt(8'h05, 16'd0, 0, 8'h00);
    check("dt05_no_drop", 64'(n_drop), 64'(1));

    send_pkt(8'h02, 16'd0, 0, 8'h00);
    send_pkt(8'h03, 16'd0, 0, 8'h00);
    check("ls_count", 64'(n_ls), 64'(1));
    check("le_count", 64'(n_le), 64'(1));

    snap = n_lsync;
    send_pkt(8'h2B, 16'd20, 2, 8'h00);
    check("trunc_count", 64'(n_trunc), 64'(1));
    check("trunc_no_last", 64'(n_last), 64'(2));
    check("trunc_lsync", 64'(lsync_o), 64'(0));
    check("trunc_lsync_cycles", 64'(n_lsync - snap), 64'(3));
    check("trunc_line_count", 64'(line_count_o), 64'(3));

    send_pkt(8'h00, 16'd0, 0, 8'h00);
    check("fs3_count", 64'(n_fs), 64'(3));
    check("fs3_line_count", 64'(line_count_o), 64'(0));
    check("fs3_fsync", 64'(fsync_o), 64'(1));

    snap = n_lsync;
    send_pkt(8'h2B, 16'd0, 1, 8'h00);
    check("wc0_line_count", 64'(line_count_o), 64'(1));
    check("wc0_lsync_cycles", 64'(n_lsync - snap), 64'(0));

    send_pkt(8'h01, 16'd0, 0, 8'h01);
`ifdef CSI2_ECC_CHECK_EN
    check("ecc_err_count", 64'(n_ecc), 64'(1));
    check("ecc_no_fe", 64'(n_fe), 64'(2));
    check("ecc_fsync_kept", 64'(fsync_o), 64'(1));
`else
    check("ecc_ignored_fe", 64'(n_fe), 64'(3));
    check("ecc_ignored_fsync", 64'(fsync_o), 64'(0));
    check("ecc_err_tied", 64'(n_ecc), 64'(0));
`endif

    // reset in the middle of a forwarded line
    bus.data_i = mk_hdr(8'h2B, 16'd40);
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    w = $urandom;
    bus.data_i = w;
    e.data = w;
    e.strb = 4'hF;
    e.last = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    bus.data_i = $urandom;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_lsync", 64'(lsync_o), 64'(0));
    check("midrst_line_count", 64'(line_count_o), 64'(0));
    check("midrst_pvalid", 64'(bus.payload_valid_o), 64'(0));
    @(negedge clk);
    bus.data_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(8'h00, 16'd0, 0, 8'h00);
    check("post_rst_fs", 64'(n_fs), 64'(4));
    check("post_rst_fsync", 64'(fsync_o), 64'(1));
    check("final_sb_drained", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
